// File: rtl/align_score_row_engine.sv
// ----------------------------------------------------------------------------
// align_score_row_engine
//
// Sequential global-alignment (Needleman-Wunsch) scorer. A QLEN-letter query
// is held in a small register file. Subject letters are streamed in one at a
// time. Each subject letter produces one matrix row, computed one cell per
// clock. The last-column score of every row is presented on a valid/ready
// output. The score of the row flagged with s_last is the global alignment
// score.
//
// Cell rule: H = max(diag + sub, up + gap, left + gap). Every sum saturates to
// the signed SW-bit range.
//
// Parameters
//   QLEN  query length in letters (>= 2); also the row buffer depth
//   LW    letter width; query letters carry one extra MSB marking gap/ambiguous
//   SW    signed score width
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   cfg_match     signed match score, captured on start
//   cfg_mismatch  signed mismatch score, captured on start
//   cfg_gap       signed gap score, captured on start
//   q_wr          query write strobe, honoured only while idle
//   q_idx         query write index (0 = column 1)
//   q_letter      query letter to write (MSB = gap/ambiguous marker)
//   start         begin an alignment, honoured only while idle
//   s_valid       subject letter valid
//   s_ready       engine can accept a subject letter
//   s_letter      subject letter
//   s_last        marks the final subject letter
//   out_valid     row score valid, held until out_ready
//   out_ready     consumer accepts out_score
//   out_score     last-column score of the row just finished
//   out_last      out_score belongs to the s_last row
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the final row is accepted
// ----------------------------------------------------------------------------
module align_score_row_engine #(
   parameter int QLEN = 16,
   parameter int LW   = 2,
   parameter int SW   = 8,
   localparam int IW  = (QLEN > 1) ? $clog2(QLEN) : 1,
   localparam int CW  = $clog2(QLEN + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic signed [SW-1:0] cfg_match,
   input  logic signed [SW-1:0] cfg_mismatch,
   input  logic signed [SW-1:0] cfg_gap,
   input  logic                 q_wr,
   input  logic [IW-1:0]        q_idx,
   input  logic [LW:0]          q_letter,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [LW-1:0]        s_letter,
   input  logic                 s_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [SW-1:0] out_score,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_WAIT_S,
      ST_ROW,
      ST_EMIT
   } state_t;

   localparam logic signed [SW-1:0] SCORE_MAX = {1'b0, {(SW-1){1'b1}}};
   localparam logic signed [SW-1:0] SCORE_MIN = {1'b1, {(SW-1){1'b0}}};

   state_t state;
   state_t state_nxt;

   logic [LW:0]          query   [0:QLEN-1];
   logic signed [SW-1:0] row_buf [0:QLEN];

   logic [CW-1:0]        cnt;
   logic signed [SW-1:0] match_r;
   logic signed [SW-1:0] mismatch_r;
   logic signed [SW-1:0] gap_r;
   logic signed [SW-1:0] init_acc;
   logic signed [SW-1:0] edge_score;
   logic signed [SW-1:0] diag_score;
   logic signed [SW-1:0] left_score;
   logic [LW-1:0]        cur_letter;
   logic                 cur_last;
   logic                 done_r;

   logic [LW:0]          q_cur;
   logic signed [SW-1:0] sub_score;
   logic signed [SW-1:0] cand_diag;
   logic signed [SW-1:0] cand_up;
   logic signed [SW-1:0] cand_left;
   logic signed [SW-1:0] h_score;
   logic signed [SW-1:0] edge_next;
   logic                 accept;
   logic                 col_end;

   // Saturating signed add. The sum is formed one bit wider than the score,
   // and disagreement between its top two bits means the true result left
   // the SW-bit range; the sign of the wide sum tells which rail to clamp to.
   function automatic logic signed [SW-1:0] sat_add(
      input logic signed [SW-1:0] a,
      input logic signed [SW-1:0] b
   );
      logic signed [SW:0] wide;
      wide = {a[SW-1], a} + {b[SW-1], b};
      if (wide[SW] != wide[SW-1]) begin
         sat_add = wide[SW] ? SCORE_MIN : SCORE_MAX;
      end else begin
         sat_add = wide[SW-1:0];
      end
   endfunction

   // Signed maximum of two scores; on a tie either operand carries the
   // same value so the choice does not matter.
   function automatic logic signed [SW-1:0] smax(
      input logic signed [SW-1:0] a,
      input logic signed [SW-1:0] b
   );
      smax = (a > b) ? a : b;
   endfunction

   // Cell datapath for column cnt of the current row. The query is stored
   // zero-based while columns count from one, hence the minus one on the
   // read index. A marked query letter scores as a gap against anything.
   always_comb begin
      q_cur     = query[IW'(cnt - CW'(1))];
      if (q_cur[LW]) begin
         sub_score = gap_r;
      end else if (q_cur[LW-1:0] == cur_letter) begin
         sub_score = match_r;
      end else begin
         sub_score = mismatch_r;
      end
      cand_diag = sat_add(diag_score, sub_score);
      cand_up   = sat_add(row_buf[cnt], gap_r);
      cand_left = sat_add(left_score, gap_r);
      h_score   = smax(cand_diag, smax(cand_up, cand_left));
      edge_next = sat_add(edge_score, gap_r);
   end

   // Handshake and column-end qualifiers shared by the FSM and datapath.
   always_comb begin
      accept  = (state == ST_WAIT_S) && s_valid;
      col_end = (cnt == CW'(QLEN));
   end

   // State register. Reset aborts any run in progress without emitting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs. s_ready and out_valid come from
   // mutually exclusive states, so they can never be high together, and the
   // output score is forced to zero outside EMIT so idle outputs read zero.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      out_valid = 1'b0;
      out_score = '0;
      out_last  = 1'b0;
      busy      = (state != ST_IDLE);
      done      = done_r;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_INIT;
            end
         end
         ST_INIT: begin
            if (col_end) begin
               state_nxt = ST_WAIT_S;
            end
         end
         ST_WAIT_S: begin
            s_ready = 1'b1;
            if (s_valid) begin
               state_nxt = ST_ROW;
            end
         end
         ST_ROW: begin
            if (col_end) begin
               state_nxt = ST_EMIT;
            end
         end
         ST_EMIT: begin
            out_valid = 1'b1;
            out_score = left_score;
            out_last  = cur_last;
            if (out_ready) begin
               state_nxt = cur_last ? ST_IDLE : ST_WAIT_S;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Control and scalar datapath registers. INIT walks cnt over 0..QLEN
   // while init_acc runs the saturated multiple of gap that seeds row 0.
   // Accepting a letter steps the left edge column down by one gap and
   // primes diag/left for column 1; each ROW cycle then shifts the old
   // row value into diag and the new cell into left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         match_r    <= '0;
         mismatch_r <= '0;
         gap_r      <= '0;
         init_acc   <= '0;
         edge_score <= '0;
         diag_score <= '0;
         left_score <= '0;
         cur_letter <= '0;
         cur_last   <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         done_r <= (state == ST_EMIT) && out_ready && cur_last;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  match_r    <= cfg_match;
                  mismatch_r <= cfg_mismatch;
                  gap_r      <= cfg_gap;
                  cnt        <= '0;
                  init_acc   <= '0;
                  edge_score <= '0;
               end
            end
            ST_INIT: begin
               init_acc   <= sat_add(init_acc, gap_r);
               edge_score <= '0;
               cnt        <= col_end ? '0 : cnt + CW'(1);
            end
            ST_WAIT_S: begin
               if (accept) begin
                  cur_letter <= s_letter;
                  cur_last   <= s_last;
                  edge_score <= edge_next;
                  diag_score <= row_buf[0];
                  left_score <= edge_next;
                  cnt        <= CW'(1);
               end
            end
            ST_ROW: begin
               diag_score <= row_buf[cnt];
               left_score <= h_score;
               cnt        <= col_end ? '0 : cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Query and row storage. Their contents are meaningless after reset, so
   // they carry no reset and are simply overwritten by the next INIT and
   // query writes. The query may only change while idle.
   always_ff @(posedge clk) begin
      if ((state == ST_IDLE) && q_wr) begin
         query[q_idx] <= q_letter;
      end
      unique case (state)
         ST_INIT: begin
            row_buf[cnt] <= init_acc;
         end
         ST_WAIT_S: begin
            if (accept) begin
               row_buf[0] <= edge_next;
            end
         end
         ST_ROW: begin
            row_buf[cnt] <= h_score;
         end
         default: begin
         end
      endcase
   end

endmodule
